// File: rtl/sq_demodulator_pkg.sv
// sq_demodulator_pkg: default widths, saturation limits and quadrant sign helper for the square-wave demodulator.
package sq_demodulator_pkg;
  localparam int R_DEF   = 14;
  localparam int PW_DEF  = 32;
  localparam int SAT_MAX = 2 ** (R_DEF - 1) - 1;
  localparam int SAT_MIN = -(2 ** (R_DEF - 1));
  function automatic logic [1:0] quad_signs(input logic [1:0] msb);
    return {msb[1], msb[1] ^ msb[0]};
  endfunction
endpackage

// File: rtl/sq_demodulator_sign_mult_sat.sv
// sign_mult_sat: multiply a signed sample by +1/-1, saturating the one unrepresentable negation.
module sign_mult_sat
  import sq_demodulator_pkg::*;
#(
  parameter int R = R_DEF
) (
  input  logic                neg,
  input  logic signed [R-1:0] a,
  output logic signed [R-1:0] y
);
  localparam logic signed [R-1:0] MIN_V = {1'b1, {(R-1){1'b0}}};
  localparam logic signed [R-1:0] MAX_V = {1'b0, {(R-1){1'b1}}};
  always_comb y = !neg ? a : (a == MIN_V) ? MAX_V : -a;
endmodule

// File: rtl/sq_demodulator.sv
// sq_demodulator: phase-accumulator square reference and 2-stage I/Q sign demodulator with saturating negation.
module sq_demodulator
  import sq_demodulator_pkg::*;
#(
  parameter int R  = R_DEF,
  parameter int PW = PW_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync,
  input  logic [PW-1:0]       freq_inc,
  input  logic [PW-1:0]       phase_ofs,
  input  logic signed [R-1:0] in,
  output logic signed [R-1:0] out_x,
  output logic signed [R-1:0] out_y,
  output logic                ref_out,
  output logic                tick
);
  logic [PW-1:0] acc_q, acc_d, p;
  logic [PW:0] sum;
  logic tick_q, tick_d, sx_q, sx_d, sy_q, sy_d;
  logic signed [R-1:0] in_q, in_d, x_q, x_d, y_q, y_d, x_m, y_m;
  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, freq_inc};
    p      = acc_q + phase_ofs;
    acc_d  = (rst || sync) ? '0 : en ? sum[PW-1:0] : acc_q;
    tick_d = !rst && !sync && en && sum[PW];
    {sx_d, sy_d} = rst ? 2'b00 : quad_signs(p[PW-1:PW-2]);
    in_d   = rst ? '0 : in;
    x_d    = rst ? '0 : x_m;
    y_d    = rst ? '0 : y_m;
  end
  sign_mult_sat #(.R(R)) u_x (.neg(sx_q), .a(in_q), .y(x_m));
  sign_mult_sat #(.R(R)) u_y (.neg(sy_q), .a(in_q), .y(y_m));
  always_ff @(posedge clk) begin
    acc_q  <= acc_d;
    tick_q <= tick_d;
    in_q   <= in_d;
    sx_q   <= sx_d;
    sy_q   <= sy_d;
    x_q    <= x_d;
    y_q    <= y_d;
  end
  assign out_x   = x_q;
  assign out_y   = y_q;
  assign tick    = tick_q;
  assign ref_out = ~acc_q[PW-1];
endmodule

// File: tb/tb_sq_demodulator.sv
// tb_sq_demodulator: directed checks of period, saturation, offset, sync, hold and reset behaviour.
module tb_sq_demodulator;
  logic clk = 1'b0, rst, en, sync, ref_out, tick;
  logic [31:0] freq_inc, phase_ofs;
  logic signed [13:0] in_s, out_x, out_y;
  int n_cmp = 0, n_bad = 0;
  sq_demodulator dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .freq_inc(freq_inc),
    .phase_ofs(phase_ofs), .in(in_s), .out_x(out_x), .out_y(out_y),
    .ref_out(ref_out), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse;
    rst = 1'b1;
    cyc;
    rst = 1'b0;
  endtask
  task automatic run_period(input bit inv);
    freq_inc = 32'h1000_0000;
    en = 1'b1;
    in_s = 14'sd1000;
    for (int i = 1; i <= 34; i++) begin
      int n, q;
      cyc;
      n = i - 2;
      q = ((n % 16) + 16) % 16 / 4;
      chk("ref_out", ref_out, ((i % 16) < 8));
      chk("tick", tick, ((i % 16) == 0));
      if (i < 2) chk("out_x_fill", out_x, 0);
      else chk("out_x_period", out_x, ((((n % 16) >= 8) ^ inv) ? -1000 : 1000));
      if (i >= 2 && !inv) chk("out_y_period", out_y, ((q == 1 || q == 2) ? -1000 : 1000));
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; freq_inc = '0; phase_ofs = '0; in_s = '0;
    cyc; cyc;
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ref", ref_out, 1);
    chk("rst_acc", dut.acc_q, 0);
    rst = 1'b0;
    run_period(1'b0);
    rst_pulse;
    phase_ofs = 32'h8000_0000;
    run_period(1'b1);
    rst_pulse;
    en = 1'b0; freq_inc = '0; phase_ofs = 32'h8000_0000; in_s = -14'sd8192;
    cyc; cyc;
    chk("sat_min_x", out_x, 8191);
    chk("sat_min_y", out_y, 8191);
    in_s = 14'sd8191;
    cyc; cyc;
    chk("neg_max_x", out_x, -8191);
    in_s = -14'sd8191;
    cyc; cyc;
    chk("neg_8191_x", out_x, 8191);
    phase_ofs = '0; in_s = -14'sd8192;
    cyc; cyc;
    chk("pass_min_x", out_x, -8192);
    chk("pass_min_y", out_y, -8192);
    rst_pulse;
    freq_inc = 32'h1000_0000; en = 1'b1; in_s = '0;
    repeat (5) cyc;
    chk("acc_5", dut.acc_q, 64'h5000_0000);
    sync = 1'b1;
    cyc;
    sync = 1'b0;
    chk("sync_acc", dut.acc_q, 0);
    chk("sync_tick", tick, 0);
    repeat (15) cyc;
    chk("acc_15", dut.acc_q, 64'hF000_0000);
    sync = 1'b1;
    cyc;
    sync = 1'b0;
    chk("sync_wrap_acc", dut.acc_q, 0);
    chk("sync_wrap_tick", tick, 0);
    rst_pulse;
    freq_inc = 32'h1000_0000; en = 1'b1; in_s = 14'sd1000;
    repeat (10) cyc;
    chk("acc_10", dut.acc_q, 64'hA000_0000);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_s = 14'(i * 411 - 4000);
      cyc;
      if (i >= 1) chk("hold_x", out_x, -((i - 1) * 411 - 4000));
      chk("hold_acc", dut.acc_q, 64'hA000_0000);
      chk("hold_ref", ref_out, 0);
      chk("hold_tick", tick, 0);
    end
    en = 1'b1; in_s = 14'sd700;
    repeat (3) cyc;
    rst = 1'b1;
    cyc;
    chk("mid_rst_x", out_x, 0);
    chk("mid_rst_y", out_y, 0);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_ref", ref_out, 1);
    rst = 1'b0; in_s = -14'sd2500;
    cyc;
    chk("post_rst_x0", out_x, 0);
    cyc;
    chk("post_rst_x", out_x, -2500);
    chk("post_rst_y", out_y, -2500);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sq_demodulator.md
SQ_DEMODULATOR -- requirements
Module: sq_demodulator

Interface
REQ-001 SHALL have parameter R, default 14: bit width of the signed input and of both outputs.
REQ-002 SHALL have parameter PW, default 32: phase accumulator width.
REQ-003 SHALL have port clk  input  1: clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1: phase accumulator advance enable.
REQ-006 SHALL have port sync  input  1: phase accumulator zero request.
REQ-007 SHALL have port freq_inc  input  PW unsigned: phase increment per cycle; f_ref = f_clk*freq_inc/2^PW.
REQ-008 SHALL have port phase_ofs  input  PW unsigned: demodulation phase offset added to the accumulator.
REQ-009 SHALL have port in  input  R signed: signal to demodulate.
REQ-010 SHALL have port out_x  output  R signed: in-phase product, fed to the downstream low-pass filter.
REQ-011 SHALL have port out_y  output  R signed: quadrature product, fed to the downstream low-pass filter.
REQ-012 SHALL have port ref_out  output  1: square reference for the modulation output, 1 = positive half-period.
REQ-013 SHALL have port tick  output  1: one-cycle pulse per accumulator wrap.

Function
REQ-014 SHALL hold phase accumulator acc[PW-1:0]; each cycle: rst -> 0; else sync -> 0; else en -> acc+freq_inc mod 2^PW; else hold.
REQ-015 SHALL give sync priority over en when both are high in the same cycle.
REQ-016 SHALL register tick high for exactly the cycle after an advance whose sum carries out of bit PW-1; sync and rst SHALL NOT generate tick.
REQ-017 SHALL form p = acc+phase_ofs mod 2^PW from the registered acc (wrap-around is silent).
REQ-018 SHALL derive sx = p[PW-1] and sy = p[PW-1] XOR p[PW-2], where sign bit 0 means multiply by +1 and 1 means multiply by -1.
REQ-019 SHALL drive ref_out = NOT acc[PW-1] directly from the acc register, independent of phase_ofs.
REQ-020 SHALL be a 2-stage pipeline: stage 1 registers in, sx and sy; stage 2 registers the signed products.
REQ-021 SHALL make out_x at cycle n+2 equal to sx(n) ? -in(n) : in(n), and out_y likewise with sy(n).
REQ-022 SHALL saturate negation: -(-2^(R-1)) becomes 2^(R-1)-1; no other value saturates; widths are unchanged.
REQ-023 SHALL keep the product pipeline running every cycle regardless of en and sync.

Reset
REQ-024 SHALL make rst clear acc, all pipeline registers, out_x, out_y and tick to 0; ref_out SHALL therefore read 1 after reset.
REQ-025 SHALL give rst asserted mid-operation effect on the next edge; the outputs SHALL read 0 for 2 cycles after release, until valid data propagates.

Structure
REQ-026 SHALL place default widths R=14 and PW=32 in the shared lock package, together with the derived saturation limits SAT_MAX = 2^(R-1)-1 and SAT_MIN = -2^(R-1).
REQ-027 SHALL instantiate a single sub-module sign_mult_sat twice (for X and for Y); it performs the conditional negation with saturation, is parameterized by R and is purely combinational.
REQ-028 SHALL keep all state (acc, tick and the pipeline registers) in sq_demodulator itself.

Verification
REQ-029 SHALL cover the period check: freq_inc=2^28, phase_ofs=0, en=1, in=1000 -> 16-cycle period; out_x = +1000 for 8 cycles and -1000 for 8 cycles, delayed 2 cycles; out_y is 90° shifted (4 cycles); tick pulses every 16 cycles.
REQ-030 SHALL cover saturation: in=-8192 with sx=1 -> out_x = 8191; in=8191 with sx=1 -> out_x = -8191.
REQ-031 SHALL cover the phase offset: phase_ofs=2^31 with freq_inc as in REQ-029 -> out_x inverted versus REQ-029; ref_out is unchanged.
REQ-032 SHALL cover sync priority: en=1 and sync=1 together at acc=0x5000_0000 -> acc = 0 on the next cycle, with no tick.
REQ-033 SHALL cover en hold: en=0 for 20 cycles -> acc and ref_out are frozen, tick stays 0, and out_x follows in with the frozen sign after 2 cycles.
REQ-034 SHALL cover mid-run reset: rst pulsed 1 cycle during operation -> all outputs 0 and ref_out = 1 on the next cycle; the output equals the product of the post-reset input 2 cycles after release.
